// File: rtl/press_classifier.sv
// Button gesture classifier: short, long and double press pulses.
// Optional auto-repeat while a long press is held: define PRESS_REPEAT_EN.
module press_classifier #(
  parameter int LONG_CYCLES    = 100,
  parameter int DBL_GAP_CYCLES = 50,
  parameter int REPEAT_CYCLES  = 25,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_in,
  output logic       short_p,
  output logic       long_p,
  output logic       double_p,
  output logic       rep_p,
  output logic       held,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } st_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYCLES - 1);

  if (LONG_CYCLES < 2 || DBL_GAP_CYCLES < 2 || REPEAT_CYCLES < 1
      || CNT_W < 2) begin : g_bad_params
    $error("press_classifier: illegal parameter values");
  end

  st_t              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             d_q;
  logic             rise, fall;
  logic             short_d, long_d, dbl_d, held_d;

  assign rise    = d_in & ~d_q;
  assign fall    = ~d_in & d_q;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign state   = st_q;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (rise) begin
          st_d  = PRESS1;
          cnt_d = '0;
        end
      end
      PRESS1: begin
        if (fall) begin
          st_d  = WAIT2;
          cnt_d = '0;
        end else if (d_in) begin
          if (cnt_q == LONG_LAST) begin
            st_d   = LONG;
            long_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WAIT2: begin
        // A rise on the timeout edge still counts as a double press
        if (rise) begin
          st_d  = PRESS2;
          dbl_d = 1'b1;
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          st_d    = IDLE;
          short_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESS2: begin
        if (fall) st_d = IDLE;
      end
      LONG: begin
        if (fall) st_d = IDLE;
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
    held_d = (st_d == PRESS1) || (st_d == PRESS2) || (st_d == LONG);
  end

  // d_q resets high so a button held through reset is ignored until released
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      d_q      <= 1'b1;
      short_p  <= 1'b0;
      long_p   <= 1'b0;
      double_p <= 1'b0;
      held     <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      d_q      <= d_in;
      short_p  <= short_d;
      long_p   <= long_d;
      double_p <= dbl_d;
      held     <= held_d;
    end
  end

`ifdef PRESS_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic             rep_d;

  assign rep_inc = (&rep_cnt_q) ? rep_cnt_q : rep_cnt_q + CNT_W'(1);

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_d     = 1'b0;
    if (st_q == LONG && st_d == LONG && d_in) begin
      if (rep_cnt_q == REP_LAST) begin
        rep_d     = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end else if (st_d != LONG) begin
      rep_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_p     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_p     <= rep_d;
    end
  end
`else
  assign rep_p = 1'b0;
`endif

endmodule
